// File: rtl/frame_loader.sv
// Writes a raster pixel stream into the hidden half of a double-buffered frame
// memory, then swaps banks at the display's next end-of-frame tick.
//
// state     | meaning
// IDLE      | waiting for a start-of-frame pixel; other pixels are dropped
// FILL      | writing pixels in raster order into bank ~rdBank
// WAIT_SWAP | frame complete; input stalled until frameTick swaps banks
module frame_loader #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int FCNT_W = 8
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic [2:0]        pixIn,
  input  logic              pixValid,
  input  logic              pixSof,
  output logic              pixReady,
  input  logic              frameTick,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [2:0]        wrData,
  output logic              rdBank,
  output logic              frameDone,
  output logic [FCNT_W-1:0] frameCount,
  output logic              syncErr
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} stateT;

  stateT            state, nextState;
  logic [IDX_W-1:0] pixelIndex, nextIndex, writeIdx;
  logic             xfer, doWrite, doSwap, setErr;

  assign xfer = pixValid && pixReady;

  always_comb begin
    nextState = state;
    nextIndex = pixelIndex;
    writeIdx  = pixelIndex;
    doWrite   = 1'b0;
    doSwap    = 1'b0;
    setErr    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && pixSof) begin
          doWrite   = 1'b1;
          writeIdx  = '0;
          nextIndex = IDX_W'(1);
          nextState = FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          doWrite = 1'b1;
          // A start-of-frame mid-fill restarts the frame from index 0.
          if (pixSof) begin
            writeIdx  = '0;
            nextIndex = IDX_W'(1);
            setErr    = 1'b1;
          end else if (pixelIndex == LAST_IDX) begin
            nextIndex = '0;
            nextState = WAIT_SWAP;
          end else begin
            nextIndex = pixelIndex + IDX_W'(1);
          end
        end
      end
      WAIT_SWAP: begin
        if (frameTick) begin
          doSwap    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      pixelIndex <= '0;
      pixReady   <= 1'b0;
      wrEn       <= 1'b0;
      wrAddr     <= '0;
      wrData     <= '0;
      rdBank     <= 1'b0;
      frameDone  <= 1'b0;
      frameCount <= '0;
      syncErr    <= 1'b0;
    end else begin
      state      <= nextState;
      pixelIndex <= nextIndex;
      pixReady   <= (nextState != WAIT_SWAP);
      wrEn       <= doWrite;
      frameDone  <= doSwap;
      if (doWrite) begin
        wrAddr <= {~rdBank, writeIdx};
        wrData <= pixIn;
      end
      if (doSwap) begin
        rdBank     <= ~rdBank;
        frameCount <= frameCount + FCNT_W'(1);
      end
      if (setErr) syncErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader, run with a reduced 16x6 image so every
// frame-level corner fits in a short simulation.
module tb_frame_loader;

  localparam int TW   = 16;
  localparam int TH   = 6;
  localparam int NPIX = TW * TH;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [2:0]  pixIn = '0;
  logic        pixValid = 1'b0;
  logic        pixSof = 1'b0;
  logic        pixReady;
  logic        frameTick = 1'b0;
  logic        wrEn;
  logic [16:0] wrAddr;
  logic [2:0]  wrData;
  logic        rdBank;
  logic        frameDone;
  logic [7:0]  frameCount;
  logic        syncErr;

  int checks = 0;
  int errors = 0;

  frame_loader #(.IMG_W(TW), .IMG_H(TH), .ADDR_W(17), .FCNT_W(8)) dut (
    .clock(clock), .resetN(resetN), .pixIn(pixIn), .pixValid(pixValid),
    .pixSof(pixSof), .pixReady(pixReady), .frameTick(frameTick), .wrEn(wrEn),
    .wrAddr(wrAddr), .wrData(wrData), .rdBank(rdBank), .frameDone(frameDone),
    .frameCount(frameCount), .syncErr(syncErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        s;
    logic [2:0]  p;
    logic        t;
    logic        eWr;
    logic [16:0] eAddr;
    logic [2:0]  eData;
    logic        eRdy;
    logic        eErr;
  } vecT;

  vecT vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic [2:0] p, input logic t);
    pixValid  = v;
    pixSof    = s;
    pixIn     = p;
    frameTick = t;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    pixValid = 1'b0; pixSof = 1'b0; pixIn = '0; frameTick = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_wrEn",       32'(wrEn), 0);
    check("rst_wrAddr",     32'(wrAddr), 0);
    check("rst_wrData",     32'(wrData), 0);
    check("rst_pixReady",   32'(pixReady), 0);
    check("rst_rdBank",     32'(rdBank), 0);
    check("rst_frameDone",  32'(frameDone), 0);
    check("rst_frameCount", 32'(frameCount), 0);
    check("rst_syncErr",    32'(syncErr), 0);
    resetN = 1'b1;
    cycle(1'b0, 1'b0, 3'd0, 1'b0);
    check("rst_ready_rise", 32'(pixReady), 1);
  endtask

  // Streams indices first..first+count-1 back to back; sof on the first pixel.
  task automatic streamFrame(input int first, input int count, input logic bankBit,
                             input logic tickLast);
    for (int i = first; i < first + count; i++) begin
      cycle(1'b1, i == first, 3'(i % 8), tickLast && (i == first + count - 1));
      check($sformatf("wrEn[%0d]", i),   32'(wrEn), 1);
      check($sformatf("wrAddr[%0d]", i), 32'(wrAddr), (32'(bankBit) << 16) | 32'(i));
      check($sformatf("wrData[%0d]", i), 32'(wrData), 32'(i % 8));
      check($sformatf("ready[%0d]", i),  32'(pixReady), (i == NPIX - 1) ? 0 : 1);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 17'h00000, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 17'h00000, 3'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 17'h10000, 3'd3, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 17'h10000, 3'd3, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 17'h10001, 3'd6, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 3'd7, 1'b1, 1'b1, 17'h10002, 3'd7, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 17'h10000, 3'd2, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 17'h10001, 3'd1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 17'h10001, 3'd1, 1'b1, 1'b1};

    // Short handshake vectors: IDLE discard, sof without valid, restart.
    doReset();
    for (int k = 0; k < 9; k++) begin
      cycle(vecs[k].v, vecs[k].s, vecs[k].p, vecs[k].t);
      check($sformatf("vec%0d_wrEn", k),   32'(wrEn), 32'(vecs[k].eWr));
      check($sformatf("vec%0d_wrAddr", k), 32'(wrAddr), 32'(vecs[k].eAddr));
      check($sformatf("vec%0d_wrData", k), 32'(wrData), 32'(vecs[k].eData));
      check($sformatf("vec%0d_ready", k),  32'(pixReady), 32'(vecs[k].eRdy));
      check($sformatf("vec%0d_syncErr", k), 32'(syncErr), 32'(vecs[k].eErr));
      check($sformatf("vec%0d_rdBank", k), 32'(rdBank), 0);
    end

    // Full frame into bank 1, stall, then swap.
    doReset();
    streamFrame(0, NPIX, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 3'd5, 1'b0);
      check("stall_wrEn",   32'(wrEn), 0);
      check("stall_ready",  32'(pixReady), 0);
      check("stall_rdBank", 32'(rdBank), 0);
      check("stall_done",   32'(frameDone), 0);
    end
    cycle(1'b0, 1'b0, 3'd0, 1'b1);
    check("swap1_rdBank", 32'(rdBank), 1);
    check("swap1_done",   32'(frameDone), 1);
    check("swap1_count",  32'(frameCount), 1);
    check("swap1_ready",  32'(pixReady), 1);
    cycle(1'b0, 1'b0, 3'd0, 1'b0);
    check("swap1_done_off", 32'(frameDone), 0);

    // Second frame goes to bank 0; asynchronous reset lands mid-fill.
    streamFrame(0, 40, 1'b0, 1'b0);
    resetN = 1'b0;
    #1;
    check("areset_wrEn",   32'(wrEn), 0);
    check("areset_ready",  32'(pixReady), 0);
    check("areset_rdBank", 32'(rdBank), 0);
    check("areset_count",  32'(frameCount), 0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    cycle(1'b0, 1'b0, 3'd0, 1'b0);
    check("areset_ready_rise", 32'(pixReady), 1);

    // Tick coincident with the last pixel must not swap.
    streamFrame(0, NPIX, 1'b1, 1'b1);
    check("cotick_rdBank", 32'(rdBank), 0);
    check("cotick_done",   32'(frameDone), 0);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 3'd0, 1'b0);
      check("cotick_hold_ready",  32'(pixReady), 0);
      check("cotick_hold_rdBank", 32'(rdBank), 0);
    end
    cycle(1'b0, 1'b0, 3'd0, 1'b1);
    check("swap2_rdBank", 32'(rdBank), 1);
    check("swap2_done",   32'(frameDone), 1);
    check("swap2_count",  32'(frameCount), 1);

    // Non-sof pixels after reset are dropped; then a restart mid-frame.
    doReset();
    for (int k = 0; k < 100; k++) begin
      cycle(1'b1, 1'b0, 3'(k % 8), 1'b0);
      check($sformatf("nosof_wrEn[%0d]", k),  32'(wrEn), 0);
      check($sformatf("nosof_ready[%0d]", k), 32'(pixReady), 1);
    end
    streamFrame(0, 50, 1'b1, 1'b0);
    check("pre_restart_syncErr", 32'(syncErr), 0);
    streamFrame(0, NPIX, 1'b1, 1'b0);
    check("restart_syncErr", 32'(syncErr), 1);
    cycle(1'b0, 1'b0, 3'd0, 1'b1);
    check("swap3_rdBank",  32'(rdBank), 1);
    check("swap3_count",   32'(frameCount), 1);
    check("swap3_syncErr", 32'(syncErr), 1);

    // Random valid gaps into bank 0: contiguous addresses, no writes in gaps.
    begin
      int expIdx = 0;
      for (int c = 0; c < 2000 && expIdx < NPIX; c++) begin
        logic v;
        v = 1'($urandom_range(0, 1));
        cycle(v, expIdx == 0, 3'(expIdx % 8), 1'b0);
        if (v) begin
          check($sformatf("gap_wrEn[%0d]", expIdx),   32'(wrEn), 1);
          check($sformatf("gap_wrAddr[%0d]", expIdx), 32'(wrAddr), 32'(expIdx));
          check($sformatf("gap_wrData[%0d]", expIdx), 32'(wrData), 32'(expIdx % 8));
          expIdx++;
        end else begin
          check($sformatf("gap_idle_wrEn[%0d]", expIdx), 32'(wrEn), 0);
        end
      end
      check("gap_frame_complete", 32'(expIdx), 32'(NPIX));
      check("gap_end_ready", 32'(pixReady), 0);
      check("gap_syncErr_sticky", 32'(syncErr), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream neighbour of the VGA display stage. Accepts a stream of 3-bit RGB pixels through a valid/ready handshake and writes them, in raster order, into the write half of a double-buffered frame memory. The image is 256x240 pixels.
- When a full frame has been written, the block waits for the display's end-of-frame pulse and then swaps banks. This guarantees the display only ever reads a complete, stable image.
- Memory address layout is {bank, pixelIndex}. The display reads with {rdBank, readPtr[15:0]}.

Parameters:
- IMG_W, 256, image width in pixels
- IMG_H, 240, image height in lines
- ADDR_W, 17, frame-memory address width: MSB is the bank select, lower ADDR_W-1 bits are the pixel index
- FCNT_W, 8, width of the completed-frame counter

Ports:
- clock  in  1  system clock; all logic on posedge
- resetN  in  1  asynchronous, active-low reset
- pixIn  in  3  pixel data {B,G,R}
- pixValid  in  1  pixIn valid
- pixSof  in  1  start-of-frame marker; meaningful only when pixValid=1; marks the first pixel of a frame
- pixReady  out  1  block can accept a pixel; a transfer happens when pixValid && pixReady
- frameTick  in  1  one-cycle pulse from the display stage at the end of the visible frame (horMax && verMax)
- wrEn  out  1  frame-memory write enable
- wrAddr  out  ADDR_W  frame-memory write address = {~rdBank, pixelIndex}
- wrData  out  3  frame-memory write data
- rdBank  out  1  bank currently shown by the display
- frameDone  out  1  one-cycle pulse when a bank swap occurs
- frameCount  out  FCNT_W  number of completed swaps; wraps modulo 2^FCNT_W
- syncErr  out  1  sticky flag: a frame was restarted early; cleared only by reset

Behaviour:
- Reset (resetN=0, asynchronous): state IDLE, pixelIndex=0, rdBank=0, wrEn=0, wrAddr=0, wrData=0, pixReady=0, frameDone=0, frameCount=0, syncErr=0.
- pixReady is registered and equals (nextState != WAIT_SWAP). It therefore rises on the first clock edge after reset is released.
- State IDLE:
  - Transfer with pixSof=1: write the pixel at index 0, set pixelIndex=1, go to FILL.
  - Transfer with pixSof=0: the pixel is consumed and discarded; no write.
- State FILL:
  - Transfer with pixSof=0: write the pixel at pixelIndex, then increment pixelIndex.
  - Transfer with pixSof=1: restart. Write the pixel at index 0, set pixelIndex=1, set syncErr=1. Stay in FILL.
  - Accepting pixel index IMG_W*IMG_H-1 (61439): go to WAIT_SWAP and set pixelIndex=0. pixReady is 0 in the following cycle.
- State WAIT_SWAP:
  - pixReady=0; no writes.
  - On frameTick=1: toggle rdBank, pulse frameDone, increment frameCount, go to IDLE. All three output updates are visible in the cycle after the tick.
- frameTick outside WAIT_SWAP is ignored. This includes a tick coincident with acceptance of the last pixel: that frame waits for the next tick.
- Write latency is 1 cycle. A transfer at edge n produces wrEn=1 with the matching wrAddr and wrData during cycle n+1; otherwise wrEn=0. wrAddr and wrData hold their last values when wrEn=0.
- wrAddr bank bit = ~rdBank sampled at the transfer edge. The block never writes to the displayed bank.
- Pixel index arithmetic is unsigned, ADDR_W-1 bits wide. The index never exceeds 61439.
- pixSof with pixValid=0 has no effect.

Test Plan:
- Reset, then 61440-pixel stream (pixSof on first, pixIn = index mod 8, pixValid always 1):
  - wrAddr runs 0x10000..0x1EFFF with wrData = index mod 8, one write per cycle.
  - pixReady=0 from the cycle after pixel 61439.
  - rdBank stays 0 until frameTick.
- In WAIT_SWAP, pulse frameTick:
  - Next cycle: rdBank=1, frameDone=1 for exactly 1 cycle, frameCount=1, pixReady=1.
  - Second frame writes 0x00000..0x0EFFF.
- 100 pixels with pixSof=0 after reset: wrEn never asserts, pixReady stays 1. The next pixSof pixel writes address 0x10000.
- pixSof at pixel 500 of a frame:
  - That pixel is written at 0x10000, syncErr=1 and remains 1.
  - The frame then needs 61440 more pixels, counting from the restart pixel, before WAIT_SWAP.
- frameTick on the same edge as pixel 61439 is accepted: no swap. The next frameTick swaps.
- Assert resetN low mid-FILL at pixel 1000:
  - Immediately (asynchronously): wrEn=0, pixReady=0, rdBank=0.
  - After release: IDLE; a pixSof pixel writes 0x10000.
- Random pixValid gaps (50%): addresses remain contiguous; no writes in gap cycles.
